// File: rtl/seq_pkg.sv
// Shared encodings for the sequencer and the RegX/RegY/RegZ/ULA datapath blocks.
package seq_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExec   = 4'd3,
    StWrite  = 4'd4,
    StHalted = 4'd5
  } state_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLdx  = 4'h1;
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpOr   = 4'h5;
  localparam logic [3:0] OpOut  = 4'h6;
  localparam logic [3:0] OpJmp  = 4'h7;
  localparam logic [3:0] OpJz   = 4'h8;
  localparam logic [3:0] OpClr  = 4'h9;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam logic [3:0] RegHold  = 4'd0;
  localparam logic [3:0] RegLoad  = 4'd1;
  localparam logic [3:0] RegClear = 4'd2;

  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluAnd = 4'd2;
  localparam logic [3:0] AluOr  = 4'd3;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OpAdd) && (op <= OpOr);
  endfunction

  // ALU opcodes are contiguous and in the same order as the ALU codes.
  function automatic logic [3:0] alu_code(input logic [3:0] op);
    return op - OpAdd;
  endfunction

  function automatic logic is_undef(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/exec_sequencer.sv
// Fetch/decode/execute sequencer: owns the pc, latches instructions from the program ROM
// and drives registered register/ALU control codes with a start/done handshake.
module exec_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned PC_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      instr,
  input  logic            acc_zero,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      imm,
  output logic [3:0]      tx,
  output logic [3:0]      ty,
  output logic [3:0]      tz,
  output logic [3:0]      tula,
  output logic [3:0]      current_state,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  state_e     state;
  logic [7:0] ir;

  assign current_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= StIdle;
      pc      <= '0;
      ir      <= 8'h00;
      tx      <= RegHold;
      ty      <= RegHold;
      tz      <= RegHold;
      tula    <= AluAdd;
      imm     <= 4'h0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      // Controls are one-cycle strobes; anything not re-asserted falls back to HOLD.
      tx   <= RegHold;
      ty   <= RegHold;
      tz   <= RegHold;
      tula <= AluAdd;
      imm  <= 4'h0;
      case (state)
        StIdle, StHalted: begin
          if (start) begin
            state   <= StFetch;
            pc      <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            illegal <= 1'b0;
          end
        end
        StFetch: state <= StDecode;
        StDecode: begin
          ir    <= instr;
          state <= StExec;
          // EXEC controls are decoded here so they leave a flop in the EXEC cycle.
          case (instr[7:4])
            OpLdx: begin
              tx  <= RegLoad;
              imm <= instr[3:0];
            end
            OpOut:   tz <= RegLoad;
            OpClr:   ty <= RegClear;
            default: begin
              if (is_alu_op(instr[7:4])) tula <= alu_code(instr[7:4]);
            end
          endcase
        end
        StExec: begin
          state <= StFetch;
          pc    <= pc + PC_W'(1);
          if (is_alu_op(ir[7:4])) begin
            state <= StWrite;
            pc    <= pc;
            ty    <= RegLoad;
            tula  <= alu_code(ir[7:4]);
          end else begin
            case (ir[7:4])
              OpJmp: pc <= PC_W'(ir[3:0]);
              OpJz: begin
                if (acc_zero) pc <= PC_W'(ir[3:0]);
              end
              OpHalt: begin
                state <= StHalted;
                pc    <= pc;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
              default: begin
                if (is_undef(ir[7:4])) illegal <= 1'b1;
              end
            endcase
          end
        end
        StWrite: begin
          state <= StFetch;
          pc    <= pc + PC_W'(1);
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench: an instruction-level model expands each program into the expected
// per-cycle output trace, which is compared against the sequencer every cycle.
module tb_exec_sequencer;
  import seq_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] pc;
    logic [3:0] tx;
    logic [3:0] ty;
    logic [3:0] tz;
    logic [3:0] tula;
    logic [3:0] imm;
    logic       busy;
    logic       done;
    logic       ill;
  } rec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       acc_zero = 1'b0;
  logic [3:0] pc, imm, tx, ty, tz, tula, current_state;
  logic       busy, done, illegal;

  logic [7:0] rom [16];
  rec_t       exp_q [$];
  int         fetch_q [$];
  int         checks = 0;
  int         errors = 0;
  int         ldx_cyc, wr_cyc, out_cyc, done_cyc;

  exec_sequencer #(.PC_W(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .instr         (instr),
    .acc_zero      (acc_zero),
    .pc            (pc),
    .imm           (imm),
    .tx            (tx),
    .ty            (ty),
    .tz            (tz),
    .tula          (tula),
    .current_state (current_state),
    .busy          (busy),
    .done          (done),
    .illegal       (illegal)
  );

  always #5 clock = ~clock;

  // Synchronous program ROM: data valid one cycle after the address.
  always @(posedge clock) instr <= rom[pc];

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, required finish before 400000");
    $fatal(1, "timeout");
  end

  function automatic rec_t mk(input logic [3:0] st, input logic [3:0] p, input logic [3:0] x,
                              input logic [3:0] y, input logic [3:0] z, input logic [3:0] u,
                              input logic [3:0] im, input logic b, input logic d,
                              input logic il);
    return {st, p, x, y, z, u, im, b, d, il};
  endfunction

  function automatic rec_t sample();
    return {current_state, pc, tx, ty, tz, tula, imm, busy, done, illegal};
  endfunction

  task automatic cmp(input string name, input rec_t got, input rec_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got st=%0d pc=%0d tx=%0d ty=%0d tz=%0d tula=%0d imm=%0d busy=%0b done=%0b ill=%0b, required st=%0d pc=%0d tx=%0d ty=%0d tz=%0d tula=%0d imm=%0d busy=%0b done=%0b ill=%0b",
               name, got.st, got.pc, got.tx, got.ty, got.tz, got.tula, got.imm, got.busy,
               got.done, got.ill, want.st, want.pc, want.tx, want.ty, want.tz, want.tula,
               want.imm, want.busy, want.done, want.ill);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Instruction-level model: walk the program and emit the visible output of every cycle.
  task automatic build(input logic az, input int max_instr, input int extra_halted);
    int p = 0;
    logic ill = 1'b0;
    logic [3:0] op, opd, ex, ey, ez, eu, ei;
    exp_q.delete();
    for (int n = 0; n < max_instr; n++) begin
      op  = rom[p][7:4];
      opd = rom[p][3:0];
      ex  = (op == 4'h1) ? 4'd1 : 4'd0;
      ei  = (op == 4'h1) ? opd : 4'd0;
      ez  = (op == 4'h6) ? 4'd1 : 4'd0;
      ey  = (op == 4'h9) ? 4'd2 : 4'd0;
      eu  = (op >= 4'h2 && op <= 4'h5) ? op - 4'd2 : 4'd0;
      exp_q.push_back(mk(4'd1, 4'(p), 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, ill));
      exp_q.push_back(mk(4'd2, 4'(p), 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, ill));
      exp_q.push_back(mk(4'd3, 4'(p), ex, ey, ez, eu, ei, 1'b1, 1'b0, ill));
      if (op >= 4'h2 && op <= 4'h5)
        exp_q.push_back(mk(4'd4, 4'(p), 4'd0, 4'd1, 4'd0, eu, 4'd0, 1'b1, 1'b0, ill));
      if (op >= 4'hA && op <= 4'hE) ill = 1'b1;
      if (op == 4'hF) begin
        for (int h = 0; h <= extra_halted; h++)
          exp_q.push_back(mk(4'd5, 4'(p), 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, ill));
        break;
      end
      if (op == 4'h7 || (op == 4'h8 && az)) p = int'(opd);
      else p = (p + 1) % 16;
    end
  endtask

  // Pulse start, then compare every cycle against the model trace. 'noisy' re-asserts start
  // during FETCH and EXEC, which must be ignored.
  task automatic run(input string name, input logic az, input int max_instr, input bit noisy);
    rec_t e, g;
    int cyc = 0;
    build(az, max_instr, 2);
    fetch_q.delete();
    ldx_cyc = -1; wr_cyc = -1; out_cyc = -1; done_cyc = -1;
    acc_zero = az;
    @(negedge clock);
    start = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      cyc++;
      e = exp_q.pop_front();
      g = sample();
      start = noisy && (e.st == 4'(StFetch) || e.st == 4'(StExec));
      cmp(name, g, e);
      if (g.st == 4'(StFetch)) fetch_q.push_back(int'(g.pc));
      if (ldx_cyc < 0 && g.tx == RegLoad) ldx_cyc = cyc;
      if (wr_cyc < 0 && g.ty == RegLoad) wr_cyc = cyc;
      if (out_cyc < 0 && g.tz == RegLoad) out_cyc = cyc;
      if (done_cyc < 0 && g.done) done_cyc = cyc;
    end
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    cmp("reset_values", sample(), mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                      input logic [7:0] w3);
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
  endtask

  initial begin
    int k;
    load(8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clock);
    do_reset();

    // LDX 3, ADD, OUT, HALT
    load(8'h13, 8'h20, 8'h60, 8'hF0);
    run("prog_basic", 1'b0, 16, 1'b0);
    chk("ldx_cycle", ldx_cyc, 3);
    chk("write_cycle", wr_cyc, 7);
    chk("out_cycle", out_cyc, 10);
    chk("done_cycle", done_cyc, 14);
    chk("busy_after_halt", int'(busy), 0);

    // Restart from HALTED with start pulses while busy.
    run("prog_noisy_start", 1'b0, 16, 1'b1);
    chk("noisy_fetch_count", fetch_q.size(), 4);

    // CLR, JZ 5, NOP x3, HALT
    load(8'h90, 8'h85, 8'h00, 8'h00);
    rom[5] = 8'hF0;
    run("jz_taken", 1'b1, 16, 1'b0);
    chk("jz_taken_fetches", fetch_q.size(), 3);
    if (fetch_q.size() == 3) chk("jz_taken_target", fetch_q[2], 5);
    run("jz_not_taken", 1'b0, 16, 1'b0);
    if (fetch_q.size() > 2) chk("jz_not_taken_next", fetch_q[2], 2);
    else chk("jz_not_taken_fetches", fetch_q.size(), 6);

    // Undefined opcode, then HALT; second start must clear illegal.
    load(8'hB0, 8'hF0, 8'h00, 8'h00);
    run("illegal_first", 1'b0, 16, 1'b0);
    chk("illegal_held", int'(illegal), 1);
    run("illegal_restart", 1'b0, 16, 1'b0);

    // JMP 15 with NOP at 15: pc wraps 15 -> 0 forever.
    load(8'h7F, 8'h00, 8'h00, 8'h00);
    run("jmp_wrap", 1'b0, 20, 1'b0);
    chk("wrap_fetches", fetch_q.size(), 20);
    if (fetch_q.size() >= 4) begin
      chk("wrap_f1", fetch_q[1], 15);
      chk("wrap_f2", fetch_q[2], 0);
      chk("wrap_f3", fetch_q[3], 15);
    end
    @(negedge clock);
    do_reset();

    // Reset asserted during WRITE of ADD.
    load(8'h20, 8'hF0, 8'h00, 8'h00);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (current_state != 4'(StWrite) && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("reached_write", int'(current_state), 4);
    chk("write_ty_load", int'(ty), 1);
    do_reset();
    run("after_mid_reset", 1'b0, 16, 1'b0);
    if (fetch_q.size() > 0) chk("restart_pc0", fetch_q[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
